// File: rtl/mean_ctrl.sv
// mean_ctrl: integer mean of 1..12 unsigned 8-bit samples.
// Samples are summed into a 12-bit accumulator. The sum is then multiplied
// by a reciprocal key (about 256/n) with an 8-step serial shift-add multiplier.
// Bits [15:8] of the product are the mean.
// Optional macro MEAN_ROUND_EN: add 128 before taking the result (round-half-up).
// Without it the result is truncated.

// Reciprocal-key table: key = floor(256/n), except n=1, which saturates to 255.
// Because every key is at most 256/n, sum*key is at most 255*256.
// Unused indices return 0.
module mean_lut (
   input  logic [3:0] idx,
   output logic [7:0] key
);
   // combinational table lookup
   always_comb begin
      key = 8'd0;
      case (idx)
         4'd1:    key = 8'd255;
         4'd2:    key = 8'd128;
         4'd3:    key = 8'd85;
         4'd4:    key = 8'd64;
         4'd5:    key = 8'd51;
         4'd6:    key = 8'd42;
         4'd7:    key = 8'd36;
         4'd8:    key = 8'd32;
         4'd9:    key = 8'd28;
         4'd10:   key = 8'd25;
         4'd11:   key = 8'd23;
         4'd12:   key = 8'd21;
         default: key = 8'd0;
      endcase
   end
endmodule

module mean_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       busy,
   output logic       err
);
   typedef enum logic [1:0] {IDLE, ACCUM, MULT, OUT} state_t;

   state_t      state;
   logic [3:0]  n_r;
   logic [3:0]  cnt;
   logic [3:0]  step;     // 0..7 = multiply steps; 8 = take the result
   logic [11:0] sum;
   logic [19:0] prod;
   logic [7:0]  key;
   logic [19:0] pp;
   logic [19:0] prod_fin;
   logic        n_legal;
   logic        prod_unused;

   mean_lut u_lut (
      .idx (n_r),
      .key (key)
   );

   assign n_legal = (n != 4'd0) && (n <= 4'd12);
   assign pp      = {8'd0, sum} << step[2:0];

`ifdef MEAN_ROUND_EN
   assign prod_fin = prod + 20'd128;
`else
   assign prod_fin = prod;
`endif

   // The upper product bits are zero for every legal n, and the fraction bits are discarded.
   assign prod_unused = ^{prod_fin[19:16], prod_fin[7:0]};

   // Sequencer: IDLE -> ACCUM -> MULT -> OUT. All outputs are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         n_r       <= 4'd0;
         cnt       <= 4'd0;
         step      <= 4'd0;
         sum       <= 12'd0;
         prod      <= 20'd0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'd0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (n_legal) begin
                     n_r      <= n;
                     sum      <= 12'd0;
                     cnt      <= 4'd0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                     state    <= ACCUM;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (in_valid) begin
                  sum <= sum + {4'd0, in_data};
                  cnt <= cnt + 4'd1;
                  if (cnt + 4'd1 == n_r) begin
                     in_ready <= 1'b0;
                     prod     <= 20'd0;
                     step     <= 4'd0;
                     state    <= MULT;
                  end
               end
            end
            MULT: begin
               if (!step[3]) begin
                  if (key[step[2:0]])
                     prod <= prod + pp;
                  step <= step + 4'd1;
               end else begin
                  out_data  <= prod_fin[15:8];
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mean_ctrl.sv
// Directed testbench for mean_ctrl. The expected results below are worked out by hand.
// Define MEAN_ROUND_EN when building the bench against the rounding build.
module tb_mean_ctrl;
   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready;
   logic       busy;
   logic       err;

   int total = 0;
   int bad   = 0;
   int smp[12];

   mean_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .n         (n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // advance one clock and settle 1ns past the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full job, using smp[0..nv-1]. gap=1 inserts an idle cycle between samples.
   // hold=1 stalls the consumer for 5 cycles and pokes start while in OUT.
   task automatic run_job(input int nv, input int gap, input int exp_out, input string tag, input bit hold);
      int lat;
      in_valid = 1'b0;
      start    = 1'b1;
      n        = 4'(nv);
      step();
      start = 1'b0;
      check({tag, "_start_in_ready"}, 32'(in_ready), 1);
      check({tag, "_start_busy"}, 32'(busy), 1);
      for (int i = 0; i < nv; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(smp[i]);
         step();
         in_valid = 1'b0;
         if (gap != 0 && i < nv - 1) begin
            step();
            check({tag, "_gap_in_ready"}, 32'(in_ready), 1);
         end
      end
      check({tag, "_last_in_ready"}, 32'(in_ready), 0);
      lat = 0;
      while (!out_valid && lat < 30) begin
         step();
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 9);
      check({tag, "_out_data"}, 32'(out_data), 32'(exp_out));
      if (hold) begin
         for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            n     = 4'd2;
            step();
            check({tag, "_hold_valid"}, 32'(out_valid), 1);
            check({tag, "_hold_data"}, 32'(out_data), 32'(exp_out));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 0);
         end
         start = 1'b0;
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_done_valid"}, 32'(out_valid), 0);
      check({tag, "_done_busy"}, 32'(busy), 0);
      $display("job %s n=%0d out=%0d exp=%0d latency=%0d", tag, nv, out_data, exp_out, lat);
      step();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; n = 4'd0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
      repeat (3) step();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);
      check("rst_state", 32'(dut.state), 0);
      rst = 1'b0;
      step();

      smp[0] = 10; smp[1] = 20; smp[2] = 30; smp[3] = 40;
      run_job(4, 0, 25, "n4", 1'b0);

      smp[0] = 1; smp[1] = 1; smp[2] = 1;
`ifdef MEAN_ROUND_EN
      run_job(3, 0, 1, "n3", 1'b0);
`else
      run_job(3, 0, 0, "n3", 1'b0);
`endif

      for (int i = 0; i < 12; i++) smp[i] = 255;
      run_job(12, 1, 251, "n12", 1'b0);
      check("n12_cnt", 32'(dut.cnt), 12);

      // illegal counts
      start = 1'b1; n = 4'd0;
      step();
      start = 1'b0;
      check("err0_pulse", 32'(err), 1);
      check("err0_busy", 32'(busy), 0);
      check("err0_in_ready", 32'(in_ready), 0);
      step();
      check("err0_clear", 32'(err), 0);
      $display("job err n=0 err_pulse_seen");
      start = 1'b1; n = 4'd13;
      step();
      start = 1'b0;
      check("err13_pulse", 32'(err), 1);
      check("err13_busy", 32'(busy), 0);
      check("err13_in_ready", 32'(in_ready), 0);
      step();
      check("err13_clear", 32'(err), 0);
      $display("job err n=13 err_pulse_seen");

      smp[0] = 200;
      run_job(1, 0, 199, "n1", 1'b1);

      // reset in the middle of a job
      start = 1'b1; n = 4'd5;
      step();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 8'd77;
         step();
      end
      in_data = 8'd99;
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      check("midrst_in_ready", 32'(in_ready), 0);
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_out_data", 32'(out_data), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_err", 32'(err), 0);
      check("midrst_state", 32'(dut.state), 0);
      check("midrst_sum", 32'(dut.sum), 0);
      check("midrst_cnt", 32'(dut.cnt), 0);
      $display("job midrst n=5 aborted after 2 samples");
      step();

      smp[0] = 100; smp[1] = 50;
      run_job(2, 0, 75, "n2", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // global watchdog so the run can never hang
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
